pwm_fader: RTL and testbench
============================

// Module: pwm_fader
// PURPOSE
//  Linear fade stage between the SPI-written threshold register file and the PWM bank.
//  Each channel's PWM threshold moves toward its SPI-written target by a global step once per fade tick.
//  Channels are served time-multiplexed by one shared step unit.
//  Bypass mode forwards targets directly, for instant brightness changes.
// PARAMETERS
//  pwm_width  16    bit width of thresholds, targets and step
//  num_pwm    12    number of PWM channels
//  tick_div   1024  clk cycles per fade tick; elaboration error if tick_div < num_pwm+2
// PORTS
//  clk       in   1                    system clock, all state on posedge
//  rst       in   1                    asynchronous, active-high reset
//  target    in   pwm_width x num_pwm  unpacked array [num_pwm-1:0]; desired thresholds from SPI regfile
//  step      in   pwm_width            per-tick increment magnitude, unsigned; shared by all channels
//  fade_en   in   1                    1 = fade mode, 0 = bypass
//  thres     out  pwm_width x num_pwm  registered thresholds to the PWM bank
//  settled   out  1                    registered; 1 when every thres[i] == target[i]
//  scan_busy out  1                    1 while the channel-scan FSM is in SCAN
// BEHAVIOUR
//  Reset: thres all 0; settled 0; scan_busy 0; prescaler 0; FSM IDLE; channel index 0.
//  Prescaler
//   - counts 0..tick_div-1 while fade_en=1, then wraps
//   - tick = (count == tick_div-1), one cycle wide
//   - held at 0 while fade_en=0
//  FSM IDLE: tick -> SCAN with idx=0.
//  FSM SCAN
//   - one channel per cycle: idx updated at the end of the cycle, idx++
//   - idx==num_pwm-1 -> IDLE
//   - scan_busy = (state==SCAN)
//  Latency: tick in cycle T -> thres[i] new value visible in cycle T+2+i.
//   A tick cannot occur in SCAN (guaranteed by the tick_div bound).
//  Step rule for channel i, unsigned, no overflow possible:
//   - d = |target[i] - thres[i]|
//   - d <= step: thres[i] <= target[i]
//   - target[i] > thres[i]: thres[i] <= thres[i] + step
//   - otherwise: thres[i] <= thres[i] - step
//   - step==0: channel unchanged (fade frozen)
//   - step >= 2^pwm_width-1: reaches target in one tick
//  target[i] is sampled in the channel's own update cycle.
//   A mid-scan change applies if that channel is not yet visited, else at the next tick.
//   A fade may reverse direction at any tick.
//  Bypass (fade_en=0)
//   - every cycle thres[i] <= target[i] for all i
//   - FSM forced to IDLE and idx=0, including abort of a scan in progress
//  fade_en 0->1: prescaler starts from 0; first tick after tick_div cycles; thres keeps the bypassed values.
//  settled <= AND over i of (thres[i]==target[i]), compared on registered values: 1-cycle lag.
//  Async rst mid-scan: all state returns to reset values immediately; no partial update survives.
// STRUCTURE
//  pulsar_pkg
//   - typedef thres_t = logic [pwm_width-1:0]
//   - typedef enum {IDLE, SCAN} fade_state_e
//   - shared helper function move_toward(cur, tgt, step)
//  Sub-module pwm_tick_gen (prescaler + tick pulse, params tick_div, en input).
//  The step unit is one shared combinational instance of move_toward, muxed by idx.
// TESTING
//  1 Reset with target all 0x1000: thres all 0, settled 0; after 1 cycle settled stays 0 until fades finish.
//  2 fade_en=1, step=0x0400, target[3]=0x1000 from 0:
//    thres[3] = 0x0400,0x0800,0x0C00,0x1000 at ticks 1-4 (visible T+5); then settled=1.
//  3 Overshoot clamp: thres[0]=0x0100, target[0]=0x0050, step=0x0400 -> thres[0]=0x0050 after one tick.
//  4 Bypass: fade_en=0, target[11]=0xFFFF -> thres[11]=0xFFFF next cycle.
//    fade_en dropped mid-scan -> scan_busy 0 next cycle.
//  5 step=0: targets differ, 3 ticks elapse -> thres unchanged, settled 0.
//    step=0xFFFF -> all channels reach target in one scan.
//  6 rst pulse at cycle T+4 of a scan -> all thres 0, scan_busy 0, next tick exactly tick_div cycles after release.

Source files
------------

// File: rtl/pulsar_pkg.sv
// pulsar_pkg: shared threshold type, scan FSM states and the move_toward step function for pwm_fader
package pulsar_pkg;
  localparam int thres_w = 16;
  typedef logic [thres_w-1:0] thres_t;
  typedef enum logic {IDLE, SCAN} fade_state_e;
  function automatic thres_t move_toward(thres_t cur, thres_t tgt, thres_t step);
    logic up;
    thres_t d;
    up = tgt > cur;
    d = up ? tgt - cur : cur - tgt;
    return d <= step ? tgt : up ? cur + step : cur - step;
  endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: fade prescaler; clk/rst/en in, one-cycle tick out every tick_div cycles while en, held at 0 otherwise
module pwm_tick_gen #(
  parameter int tick_div = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int cnt_w = tick_div > 1 ? $clog2(tick_div) : 1;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == cnt_w'(tick_div - 1);
  always_comb cnt_d = !en || tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_fader.sv
// pwm_fader: time-multiplexed linear fade of thres toward target per tick (or bypass); ports clk, rst, target, step, fade_en, thres, settled, scan_busy
module pwm_fader
  import pulsar_pkg::*;
#(
  parameter int pwm_width = 16,
  parameter int num_pwm   = 12,
  parameter int tick_div  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [pwm_width-1:0] target [num_pwm-1:0],
  input  logic [pwm_width-1:0] step,
  input  logic                 fade_en,
  output logic [pwm_width-1:0] thres [num_pwm-1:0],
  output logic                 settled,
  output logic                 scan_busy
);
  localparam int idx_w = num_pwm > 1 ? $clog2(num_pwm) : 1;
  if (tick_div < num_pwm + 2) begin : g_bad_div
    $error("pwm_fader: tick_div must be at least num_pwm+2");
  end
  if (pwm_width != thres_w) begin : g_bad_width
    $error("pwm_fader: pwm_width must match pulsar_pkg::thres_w");
  end
  fade_state_e state_q, state_d;
  logic [idx_w-1:0] idx_q, idx_d;
  logic [pwm_width-1:0] thres_q [num_pwm-1:0];
  logic [pwm_width-1:0] thres_d [num_pwm-1:0];
  logic settled_q, settled_d, tick, last;
  thres_t stepped;
  pwm_tick_gen #(.tick_div(tick_div)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (fade_en),
    .tick(tick)
  );
  assign last = idx_q == idx_w'(num_pwm - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  always_comb begin
    state_d = !fade_en ? IDLE : state_q == IDLE ? (tick ? SCAN : IDLE) : (last ? IDLE : SCAN);
    idx_d   = !fade_en || state_q == IDLE || last ? '0 : idx_q + 1'b1;
  end
  assign scan_busy = state_q == SCAN;
  always_comb begin
    stepped   = move_toward(thres_q[idx_q], target[idx_q], step);
    settled_d = 1'b1;
    for (int i = 0; i < num_pwm; i++) begin
      thres_d[i] = !fade_en ? target[i] : scan_busy && idx_q == idx_w'(i) ? stepped : thres_q[i];
      settled_d  = settled_d & (thres_q[i] == target[i]);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < num_pwm; i++) thres_q[i] <= '0;
      settled_q <= 1'b0;
    end else begin
      thres_q   <= thres_d;
      settled_q <= settled_d;
    end
  assign thres   = thres_q;
  assign settled = settled_q;
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: scoreboard bench for pwm_fader fade timing, clamp, bypass, step limits and async reset
module tb_pwm_fader;
  localparam int W = 16;
  localparam int N = 12;
  localparam int T = 16;
  typedef struct {
    int cyc;
    int ch;
    logic [W-1:0] val;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fade_en = 1'b0;
  logic settled, scan_busy;
  logic [W-1:0] step = '0;
  logic [W-1:0] target [N-1:0];
  logic [W-1:0] thres [N-1:0];
  int cyc = 0;
  int base = 0;
  int n_assert = 0;
  int n_fail = 0;
  exp_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pwm_fader #(.pwm_width(W), .num_pwm(N), .tick_div(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .target   (target),
    .step     (step),
    .fade_en  (fade_en),
    .thres    (thres),
    .settled  (settled),
    .scan_busy(scan_busy)
  );
  // ch >= 0 checks thres[ch]; -1 checks settled; -2 checks scan_busy; c is cycles after base
  function automatic void expect_at(int c, int ch, logic [W-1:0] v, string n);
    sb.push_back('{base + c, ch, v, n});
  endfunction
  task automatic set_all(logic [W-1:0] v);
    for (int i = 0; i < N; i++) target[i] = v;
  endtask
  task automatic sb_drain();
    exp_t e;
    logic [W-1:0] obs;
    int guard = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      guard++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        obs = e.ch >= 0 ? thres[e.ch] : e.ch == -1 ? W'(settled) : W'(scan_busy);
        n_assert++;
        if (obs !== e.val || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s at cycle +%0d: got %h, expected %h", e.name, cyc - base, obs, e.val);
        end
      end
      if (guard > 400) begin
        n_assert++;
        n_fail++;
        $display("FAIL scoreboard timeout: %0d entries never reached", sb.size());
        sb.delete();
      end
    end
  endtask
  task automatic test_reset();
    set_all(16'h1000);
    fade_en = 1'b1;
    step = 16'h0400;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      n_assert++;
      if (thres[i] !== '0) begin
        n_fail++;
        $display("FAIL reset thres[%0d]: got %h, expected 0000", i, thres[i]);
      end
    end
    n_assert++;
    if (settled !== 1'b0 || scan_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: settled=%b scan_busy=%b, expected 0 0", settled, scan_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
    expect_at(1, -1, 16'h0, "settled while fading");
    expect_at(T - 1, -2, 16'h0, "busy before first tick");
    expect_at(T, -2, 16'h1, "busy at scan start");
    expect_at(T + 11, 11, 16'h0, "thres11 before visit");
    expect_at(T + 11, -2, 16'h1, "busy last channel");
    expect_at(T + 12, 11, 16'h0400, "thres11 first step");
    expect_at(T + 12, -2, 16'h0, "busy after scan");
    sb_drain();
  endtask
  task automatic test_fade();
    set_all(16'h0);
    target[3] = 16'h1000;
    step = 16'h0400;
    fade_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
    for (int t = 1; t <= 4; t++) begin
      expect_at(t * T + 3, 3, W'((t - 1) * 'h400), "fade ch3 before update");
      expect_at(t * T + 4, 3, W'(t * 'h400), "fade ch3 step");
    end
    expect_at(4 * T + 4, -1, 16'h0, "settled lag");
    expect_at(4 * T + 5, -1, 16'h1, "settled after fade");
    sb_drain();
  endtask
  task automatic test_clamp();
    fade_en = 1'b0;
    set_all(16'h0);
    target[0] = 16'h0100;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (thres[0] !== 16'h0100) begin
      n_fail++;
      $display("FAIL clamp preload: got %h, expected 0100", thres[0]);
    end
    fade_en = 1'b1;
    target[0] = 16'h0050;
    step = 16'h0400;
    base = cyc;
    expect_at(T, 0, 16'h0100, "clamp before update");
    expect_at(T + 1, 0, 16'h0050, "overshoot clamp");
    expect_at(T + 2, -1, 16'h1, "settled after clamp");
    sb_drain();
  endtask
  task automatic test_bypass();
    fade_en = 1'b0;
    target[11] = 16'hFFFF;
    base = cyc;
    expect_at(1, 11, 16'hFFFF, "bypass ch11");
    sb_drain();
    fade_en = 1'b1;
    step = 16'h0001;
    base = cyc;
    expect_at(T - 1, -2, 16'h0, "busy before tick");
    expect_at(T + 3, -2, 16'h1, "busy mid scan");
    sb_drain();
    fade_en = 1'b0;
    target[5] = 16'h1234;
    base = cyc;
    expect_at(1, -2, 16'h0, "scan abort");
    expect_at(1, 5, 16'h1234, "bypass ch5");
    sb_drain();
  endtask
  task automatic test_step_limits();
    logic [W-1:0] want [N-1:0];
    step = 16'h0;
    target[5] = 16'h2000;
    fade_en = 1'b1;
    base = cyc;
    expect_at(3 * T + 12, 5, 16'h1234, "step0 frozen");
    expect_at(3 * T + 12, -1, 16'h0, "step0 not settled");
    sb_drain();
    step = 16'hFFFF;
    for (int i = 0; i < N; i++) begin
      want[i] = i == 0 ? 16'hFFFF : i == 11 ? 16'h0 : W'(i * 'h1357);
      target[i] = want[i];
    end
    base = cyc;
    expect_at(T - 1, 11, 16'hFFFF, "full swing before visit");
    for (int i = 0; i < N; i++) expect_at(T, i, want[i], "full step one scan");
    expect_at(T + 1, -1, 16'h1, "settled after full step");
    sb_drain();
  endtask
  task automatic test_async_reset();
    fade_en = 1'b0;
    set_all(16'h0800);
    @(negedge clk);
    fade_en = 1'b1;
    set_all(16'h0);
    step = 16'h0100;
    base = cyc;
    expect_at(T + 3, 2, 16'h0700, "fade down");
    expect_at(T + 3, 3, 16'h0800, "not yet visited");
    expect_at(T + 3, -2, 16'h1, "busy before rst");
    sb_drain();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      n_assert++;
      if (thres[i] !== '0) begin
        n_fail++;
        $display("FAIL async rst thres[%0d]: got %h, expected 0000", i, thres[i]);
      end
    end
    n_assert++;
    if (scan_busy !== 1'b0 || settled !== 1'b0) begin
      n_fail++;
      $display("FAIL async rst flags: scan_busy=%b settled=%b, expected 0 0", scan_busy, settled);
    end
    set_all(16'h0040);
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
    expect_at(T - 1, -2, 16'h0, "no early tick after rst");
    expect_at(T, -2, 16'h1, "tick after release");
    expect_at(T, 0, 16'h0, "ch0 before update");
    expect_at(T + 1, 0, 16'h0040, "ch0 after release");
    sb_drain();
  endtask
  initial begin
    test_reset();
    test_fade();
    test_clamp();
    test_bypass();
    test_step_limits();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
